mips_cpu_harvard_core: RTL and testbench

//  Single-cycle MIPS-I subset CPU with separate instruction and data buses (Harvard).
//  Top-level core of the CPU subsystem; external combinational instruction ROM and data RAM attach directly.

---
 rtl/mips_cpu_harvard_core.sv | 227 ++++++++++++++++++++++
 tb/tb_mips_cpu_harvard_core.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_harvard_core.sv
// mips_cpu_harvard_core: single-cycle MIPS-I subset core, Harvard buses.
// Each enabled clock executes the instruction at r_pc. The core keeps a
// separate next-PC register so that the instruction after a branch or jump
// (the delay slot) always runs before control moves to the target.
// Buses are little-endian words and are byte-swapped at the core boundary,
// so everything inside the core is big-endian.
// Optional feature: define MIPS_VAR_SHIFT_EN to decode SLLV/SRLV/SRAV.
// Without it those funct codes behave as NOP.
//
// Run/halt controller states:
//   state  | meaning
//   S_RUN  | fetching and executing, active=1
//   S_HALT | PC has reached 0x00000000; all state frozen, active=0

module mips_cpu_harvard_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
`ifdef MIPS_VAR_SHIFT_EN
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
`endif
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  function automatic logic [31:0] f_swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] r_gpr [0:31];

  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus8;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_load_val;

  logic        w_wr_en;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_jump;
  logic [31:0] w_jump_target;
  logic        w_step;

  assign w_instr    = f_swap(instr_readdata);
  assign w_op       = w_instr[31:26];
  assign w_rs       = w_instr[25:21];
  assign w_rt       = w_instr[20:16];
  assign w_rd       = w_instr[15:11];
  assign w_shamt    = w_instr[10:6];
  assign w_funct    = w_instr[5:0];
  assign w_rs_val   = r_gpr[w_rs];
  assign w_rt_val   = r_gpr[w_rt];
  assign w_imm_sext = {{16{w_instr[15]}}, w_instr[15:0]};
  assign w_imm_zext = {16'h0000, w_instr[15:0]};
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_plus8 = r_pc + 32'd8;
  assign w_br_target = w_pc_plus4 + (w_imm_sext << 2);
  assign w_j_target  = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
  assign w_load_val  = f_swap(data_readdata);

  assign active        = (r_state == S_RUN);
  assign w_step        = active && clk_enable;
  assign register_v0   = r_gpr[2];
  assign instr_address = r_pc;
  assign data_address  = (w_rs_val + w_imm_sext) & 32'hFFFF_FFFC;
  assign data_writedata = f_swap(w_rt_val);
  // Strobes are killed during reset and once halted; a store also needs the enable.
  assign data_read  = w_is_lw && active && !reset;
  assign data_write = w_is_sw && w_step && !reset;

  // Decode and execute: register write-back, memory strobes and control transfer.
  always_comb begin
    w_wr_en       = 1'b0;
    w_wr_addr     = w_rt;
    w_wr_data     = 32'h0;
    w_is_lw       = 1'b0;
    w_is_sw       = 1'b0;
    w_jump        = 1'b0;
    w_jump_target = w_br_target;
    case (w_op)
      OP_SPECIAL: begin
        w_wr_addr = w_rd;
        case (w_funct)
          F_SLL:  begin w_wr_en = 1'b1; w_wr_data = w_rt_val << w_shamt; end
          F_SRL:  begin w_wr_en = 1'b1; w_wr_data = w_rt_val >> w_shamt; end
          F_SRA:  begin w_wr_en = 1'b1; w_wr_data = $signed(w_rt_val) >>> w_shamt; end
`ifdef MIPS_VAR_SHIFT_EN
          F_SLLV: begin w_wr_en = 1'b1; w_wr_data = w_rt_val << w_rs_val[4:0]; end
          F_SRLV: begin w_wr_en = 1'b1; w_wr_data = w_rt_val >> w_rs_val[4:0]; end
          F_SRAV: begin w_wr_en = 1'b1; w_wr_data = $signed(w_rt_val) >>> w_rs_val[4:0]; end
`endif
          F_JR:   begin w_jump = 1'b1; w_jump_target = w_rs_val; end
          F_JALR: begin
            w_jump = 1'b1; w_jump_target = w_rs_val;
            w_wr_en = 1'b1; w_wr_data = w_pc_plus8;
          end
          F_ADDU: begin w_wr_en = 1'b1; w_wr_data = w_rs_val + w_rt_val; end
          F_SUBU: begin w_wr_en = 1'b1; w_wr_data = w_rs_val - w_rt_val; end
          F_AND:  begin w_wr_en = 1'b1; w_wr_data = w_rs_val & w_rt_val; end
          F_OR:   begin w_wr_en = 1'b1; w_wr_data = w_rs_val | w_rt_val; end
          F_XOR:  begin w_wr_en = 1'b1; w_wr_data = w_rs_val ^ w_rt_val; end
          F_NOR:  begin w_wr_en = 1'b1; w_wr_data = ~(w_rs_val | w_rt_val); end
          F_SLT:  begin
            w_wr_en = 1'b1; w_wr_data = {31'h0, $signed(w_rs_val) < $signed(w_rt_val)};
          end
          F_SLTU: begin w_wr_en = 1'b1; w_wr_data = {31'h0, w_rs_val < w_rt_val}; end
          default: ;
        endcase
      end
      // Only BLTZ (rt=0) and BGEZ (rt=1); the linking REGIMM forms are NOPs.
      OP_REGIMM: begin
        if (w_rt == 5'd0)      w_jump = w_rs_val[31];
        else if (w_rt == 5'd1) w_jump = !w_rs_val[31];
      end
      OP_J:    begin w_jump = 1'b1; w_jump_target = w_j_target; end
      OP_JAL:  begin
        w_jump = 1'b1; w_jump_target = w_j_target;
        w_wr_en = 1'b1; w_wr_addr = 5'd31; w_wr_data = w_pc_plus8;
      end
      OP_BEQ:  w_jump = (w_rs_val == w_rt_val);
      OP_BNE:  w_jump = (w_rs_val != w_rt_val);
      OP_BLEZ: w_jump = w_rs_val[31] || (w_rs_val == 32'h0);
      OP_BGTZ: w_jump = !w_rs_val[31] && (w_rs_val != 32'h0);
      OP_ADDIU: begin w_wr_en = 1'b1; w_wr_data = w_rs_val + w_imm_sext; end
      OP_SLTI:  begin
        w_wr_en = 1'b1; w_wr_data = {31'h0, $signed(w_rs_val) < $signed(w_imm_sext)};
      end
      OP_SLTIU: begin w_wr_en = 1'b1; w_wr_data = {31'h0, w_rs_val < w_imm_sext}; end
      OP_ANDI:  begin w_wr_en = 1'b1; w_wr_data = w_rs_val & w_imm_zext; end
      OP_ORI:   begin w_wr_en = 1'b1; w_wr_data = w_rs_val | w_imm_zext; end
      OP_XORI:  begin w_wr_en = 1'b1; w_wr_data = w_rs_val ^ w_imm_zext; end
      OP_LUI:   begin w_wr_en = 1'b1; w_wr_data = {w_instr[15:0], 16'h0000}; end
      OP_LW:    begin w_is_lw = 1'b1; w_wr_en = 1'b1; w_wr_data = w_load_val; end
      OP_SW:    w_is_sw = 1'b1;
      default: ;
    endcase
  end

  // Run/halt state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_next;
  end

  // Halt on the edge that would move the PC to address 0.
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_RUN && clk_enable && r_npc == 32'h0) w_state_next = S_HALT;
  end

  // PC pair and register file: one instruction retires per enabled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= RESET_VECTOR;
      r_npc <= RESET_VECTOR + 32'd4;
      for (int i = 0; i < 32; i++) r_gpr[i] <= 32'h0;
    end else if (w_step) begin
      r_pc  <= r_npc;
      r_npc <= w_jump ? w_jump_target : (r_npc + 32'd4);
      if (w_wr_en && w_wr_addr != 5'd0) r_gpr[w_wr_addr] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Directed-program bench for mips_cpu_harvard_core with ROM/RAM models.
module tb_mips_cpu_harvard_core;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  logic [31:0] rom [0:63];
  logic [31:0] ram [0:255] = '{default: 32'h0};
  int          n_wr = 0;
  int          n_both = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  mips_cpu_harvard_core dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .register_v0(register_v0), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .data_address(data_address),
    .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] swp(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [31:0] e_i(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] e_r(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  // Instruction ROM at BASE (words stored big-endian, presented swapped); 0 elsewhere.
  always_comb begin
    instr_readdata = 32'h0;
    if (instr_address >= BASE && instr_address < BASE + 32'd256)
      instr_readdata = swp(rom[(instr_address - BASE) >> 2]);
  end

  assign data_readdata = ram[data_address[9:2]];

  // Data RAM write port and bus-protocol monitor.
  always @(posedge clk) begin
    if (data_write) begin
      ram[data_address[9:2]] <= data_writedata;
      n_wr <= n_wr + 1;
    end
    if (data_write && data_read) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic clr_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_to_halt(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (active && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, {31'h0, active}, 32'h0);
  endtask

  task automatic load_prog_d(input logic [15:0] addr);
    clr_rom();
    rom[0] = e_i(6'h0F, 0, 4, 16'h1234);
    rom[1] = e_i(6'h0D, 4, 4, 16'h5678);
    rom[2] = e_i(6'h2B, 0, 4, addr);
    rom[3] = e_i(6'h23, 0, 2, addr);
    rom[4] = e_r(0, 0, 0, 0, 6'h08);
    rom[5] = 32'h0;
  endtask

  initial begin
    int wr0;
    logic [31:0] pc_hold;
    logic [31:0] exp_c;

    // A: reset state, ADDIU to v0, JR $0 with delay slot, halt timing
    clr_rom();
    rom[0] = e_i(6'h09, 0, 2, 16'h7FFF);
    rom[1] = e_r(0, 0, 0, 0, 6'h08);
    rom[2] = 32'h0;
    #1;
    chk("rst_dwrite", {31'h0, data_write}, 32'h0);
    chk("rst_dread", {31'h0, data_read}, 32'h0);
    do_reset();
    chk("rst_pc", instr_address, BASE);
    chk("rst_active", {31'h0, active}, 32'h1);
    chk("rst_v0", register_v0, 32'h0);
    step(2);
    chk("a_pc_slot", instr_address, BASE + 32'd8);
    chk("a_active_slot", {31'h0, active}, 32'h1);
    step(1);
    chk("a_halt", {31'h0, active}, 32'h0);
    chk("a_pc0", instr_address, 32'h0);
    chk("a_v0", register_v0, 32'h0000_7FFF);
    wr0 = n_wr;
    step(4);
    chk("a_hold_pc", instr_address, 32'h0);
    chk("a_hold_v0", register_v0, 32'h0000_7FFF);
    chk("a_hold_wr", n_wr - wr0, 32'h0);
    chk("a_hold_dread", {31'h0, data_read}, 32'h0);

    // B: fill 0x100..0x170 with all-ones via a store loop
    clr_rom();
    rom[0] = e_i(6'h0F, 0, 8, 16'hFFFF);
    rom[1] = e_i(6'h0D, 8, 8, 16'hFFFF);
    rom[2] = e_i(6'h09, 0, 9, 16'h0100);
    rom[3] = e_i(6'h09, 0, 10, 16'h0170);
    rom[4] = e_i(6'h2B, 9, 8, 16'h0000);
    rom[5] = e_i(6'h05, 9, 10, 16'hFFFE);
    rom[6] = e_i(6'h09, 9, 9, 16'h0004);
    rom[7] = e_r(0, 0, 0, 0, 6'h08);
    rom[8] = e_r(9, 0, 2, 0, 6'h21);
    do_reset();
    wr0 = n_wr;
    run_to_halt(400, "b");
    chk("b_nstores", n_wr - wr0, 32'd29);
    chk("b_v0", register_v0, 32'h0000_0174);
    for (int a = 'h100; a <= 'h170; a += 4)
      chk($sformatf("b_ram_%0h", a), swp(ram[a >> 2]), 32'hFFFF_FFFF);
    chk("b_ram_below", ram['hFC >> 2], 32'h0);
    chk("b_ram_above", ram['h174 >> 2], 32'h0);

    // C: taken BEQ, delay slot once, fall-through skipped; SLLV per build
    clr_rom();
    rom[0] = e_i(6'h09, 0, 2, 16'h0005);
    rom[1] = e_i(6'h04, 0, 0, 16'h0002);
    rom[2] = e_i(6'h09, 2, 2, 16'h0001);
    rom[3] = e_i(6'h09, 2, 2, 16'h0100);
    rom[4] = e_r(2, 2, 2, 0, 6'h04);
    rom[5] = e_r(0, 0, 0, 0, 6'h08);
    rom[6] = e_i(6'h09, 2, 2, 16'h0010);
`ifdef MIPS_VAR_SHIFT_EN
    exp_c = 32'h0000_0190;
`else
    exp_c = 32'h0000_0016;
`endif
    do_reset();
    run_to_halt(50, "c");
    chk("c_v0", register_v0, exp_c);

    // D: store then load, bus byte order, strobe exclusivity
    load_prog_d(16'h0200);
    do_reset();
    step(2);
    chk("d_sw_write", {31'h0, data_write}, 32'h1);
    chk("d_sw_read", {31'h0, data_read}, 32'h0);
    chk("d_sw_addr", data_address, 32'h0000_0200);
    chk("d_sw_bus", data_writedata, 32'h7856_3412);
    step(1);
    chk("d_lw_read", {31'h0, data_read}, 32'h1);
    chk("d_lw_write", {31'h0, data_write}, 32'h0);
    run_to_halt(50, "d");
    chk("d_v0", register_v0, 32'h1234_5678);
    chk("d_ram", ram['h200 >> 2], 32'h7856_3412);

    // E: ALU ops, JAL link/target, BLTZ taken, BGTZ not taken
    clr_rom();
    rom[0]  = e_i(6'h09, 0, 3, 16'hFFF8);
    rom[1]  = e_i(6'h09, 0, 4, 16'h0003);
    rom[2]  = e_r(4, 3, 5, 0, 6'h23);
    rom[3]  = e_r(0, 3, 6, 1, 6'h03);
    rom[4]  = e_r(0, 3, 7, 28, 6'h02);
    rom[5]  = e_r(3, 4, 11, 0, 6'h2A);
    rom[6]  = e_r(3, 4, 12, 0, 6'h2B);
    rom[7]  = e_i(6'h0E, 3, 13, 16'hFFFF);
    rom[8]  = e_r(3, 4, 14, 0, 6'h27);
    rom[9]  = e_i(6'h0B, 4, 15, 16'hFFFF);
    rom[10] = {6'h03, 26'(((BASE + 32'd56) >> 2) & 32'h03FF_FFFF)};
    rom[11] = e_r(0, 4, 16, 4, 6'h00);
    rom[12] = e_i(6'h09, 0, 2, 16'h0BAD);
    rom[13] = 32'h0;
    rom[14] = e_i(6'h2B, 0, 5, 16'h0300);
    rom[15] = e_i(6'h2B, 0, 6, 16'h0304);
    rom[16] = e_i(6'h2B, 0, 7, 16'h0308);
    rom[17] = e_i(6'h2B, 0, 11, 16'h030C);
    rom[18] = e_i(6'h2B, 0, 12, 16'h0310);
    rom[19] = e_i(6'h2B, 0, 13, 16'h0314);
    rom[20] = e_i(6'h2B, 0, 14, 16'h0318);
    rom[21] = e_i(6'h2B, 0, 15, 16'h031C);
    rom[22] = e_i(6'h2B, 0, 16, 16'h0320);
    rom[23] = e_i(6'h2B, 0, 31, 16'h0324);
    rom[24] = e_i(6'h01, 3, 0, 16'h0001);
    rom[25] = e_i(6'h09, 2, 2, 16'h0001);
    rom[26] = e_i(6'h07, 3, 0, 16'h0002);
    rom[27] = e_i(6'h09, 2, 2, 16'h0002);
    rom[28] = e_i(6'h0D, 2, 2, 16'h0040);
    rom[29] = e_r(0, 0, 0, 0, 6'h08);
    rom[30] = 32'h0;
    do_reset();
    run_to_halt(100, "e");
    chk("e_subu", swp(ram['h300 >> 2]), 32'h0000_000B);
    chk("e_sra", swp(ram['h304 >> 2]), 32'hFFFF_FFFC);
    chk("e_srl", swp(ram['h308 >> 2]), 32'h0000_000F);
    chk("e_slt", swp(ram['h30C >> 2]), 32'h0000_0001);
    chk("e_sltu", swp(ram['h310 >> 2]), 32'h0000_0000);
    chk("e_xori", swp(ram['h314 >> 2]), 32'hFFFF_0007);
    chk("e_nor", swp(ram['h318 >> 2]), 32'h0000_0004);
    chk("e_sltiu", swp(ram['h31C >> 2]), 32'h0000_0001);
    chk("e_sll_slot", swp(ram['h320 >> 2]), 32'h0000_0030);
    chk("e_jal_link", swp(ram['h324 >> 2]), BASE + 32'h30);
    chk("e_v0", register_v0, 32'h0000_0043);

    // F: clk_enable low for 5 cycles with a store pending
    load_prog_d(16'h0240);
    do_reset();
    step(2);
    clk_enable = 1'b0;
    pc_hold = instr_address;
    wr0 = n_wr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("f_pc_frozen_%0d", i), instr_address, pc_hold);
    end
    chk("f_no_write_pulse", n_wr - wr0, 32'h0);
    chk("f_ram_untouched", ram['h240 >> 2], 32'h0);
    clk_enable = 1'b1;
    run_to_halt(50, "f");
    chk("f_v0", register_v0, 32'h1234_5678);
    chk("f_ram", ram['h240 >> 2], 32'h7856_3412);

    // G: reset asserted while a store is on the bus aborts it
    load_prog_d(16'h0280);
    do_reset();
    step(2);
    chk("g_sw_pending", {31'h0, data_write}, 32'h1);
    reset = 1'b1;
    #1;
    chk("g_rst_dwrite", {31'h0, data_write}, 32'h0);
    chk("g_rst_pc", instr_address, BASE);
    @(negedge clk);
    chk("g_store_aborted", ram['h280 >> 2], 32'h0);
    reset = 1'b0;
    run_to_halt(50, "g");
    chk("g_ram_after", ram['h280 >> 2], 32'h7856_3412);

    chk("never_both_strobes", n_both, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
